pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Parametrised successor to the fixed-step 16-bit program counter.
- Owns the PC and issues instruction-memory requests over a req/gnt/rvalid handshake.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Supports redirect (branch/jump) with flush of buffered and in-flight fetches, plus a halt mode; sits between instruction memory and the decode/control stage.

Parameters:
- ADDR_W, 16, PC / instruction-address width.
- INSTR_W, 16, instruction width in bits; multiple of 8. PC step = INSTR_W/8.
- RESET_PC, 0, PC value loaded at reset.
- BUF_DEPTH, 2, instruction buffer entries; also caps outstanding fetches. Power of two, ≥2.

Ports:
- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- Redirect_valid  in  1  load new PC, flush buffer and in-flight fetches
- Redirect_pc  in  ADDR_W  target PC; low log2(INSTR_W/8) bits ignored (treated as 0)
- Halt  in  1  level; stop issuing new fetches
- Imem_req  out  1  fetch request
- Imem_addr  out  ADDR_W  fetch address (= PC while Imem_req)
- Imem_gnt  in  1  request accepted this cycle
- Imem_rvalid  in  1  in-order response valid; at least 1 cycle after its gnt
- Imem_rdata  in  INSTR_W  response data
- Instr_valid  out  1  buffer head valid
- Instr_ready  in  1  decode accepts head
- Instr  out  INSTR_W  head instruction
- Instr_pc  out  ADDR_W  address of head instruction
- Outstanding  out  log2(BUF_DEPTH)+1  in-flight fetch count (debug)

Behaviour:
- Reset (async assert, sync deassert by the system):
  - PC=RESET_PC; buffer empty; Outstanding=0; drop count=0; state=IDLE.
  - All outputs 0, except Imem_addr=RESET_PC.
- FSM states: IDLE, RUN, HALTED.
  - IDLE → RUN after exactly one cycle. No request is issued in IDLE.
  - RUN → HALTED when Halt=1 and Redirect_valid=0.
  - HALTED → RUN on Redirect_valid=1, or when Halt=0.
  - Redirect in RUN stays in RUN.
- Issue rule:
  - Imem_req=1 iff state=RUN, Halt=0, and (occupancy + Outstanding + drop count) < BUF_DEPTH.
  - Imem_req is held with a stable Imem_addr until gnt or redirect.
- On Imem_req & Imem_gnt: Outstanding++, PC ← PC + INSTR_W/8. Wraps modulo 2^ADDR_W (0xFFFE → 0x0000 for defaults).
- Each fetch carries its address into a PC tag FIFO of depth BUF_DEPTH; the tag pops on response.
- On Imem_rvalid:
  - If drop count > 0: decrement drop count, discard data.
  - Else: Outstanding--, push {rdata, tag} to the buffer. The issue rule guarantees space; overflow is impossible and is asserted on in simulation.
- Instr_valid = buffer non-empty; it is registered, with no combinational path from Imem_rvalid. Pop on Instr_valid & Instr_ready.
- Latency: gnt at cycle N with rvalid at N+1 → Instr_valid at N+2.
- Redirect_valid (highest priority) at an edge:
  - PC ← Redirect_pc; buffer emptied.
  - drop count ← Outstanding + (1 if a gnt occurs this cycle) − (1 if a non-dropped rvalid occurs this cycle). An rvalid arriving in the redirect cycle is discarded. Outstanding ← 0.
  - Any pop in the same cycle is irrelevant; the flush wins.
  - Fetch at the new PC may issue the following cycle.
- Halt mid-stream: outstanding responses still land in the buffer, and decode may drain them. Only new issue stops.
- Full buffer with Instr_ready=0: Imem_req=0 and the PC holds. No loss, no duplication.
- Reset asserted mid-operation: immediate return to reset values; in-flight memory responses after reset release are the system's responsibility (memory is reset too).

Decomposition:
- Shared package cpu_pkg: ADDR_W/INSTR_W defaults, RESET_PC, fetch state enum {IDLE, RUN, HALTED}.
- One sub-module: sync_fifo (parametrised width/depth, push/pop/full/empty/count). It is instantiated twice: instruction buffer {INSTR_W+ADDR_W} and PC tag FIFO.

Test Plan:
- Reset release, zero-wait memory (gnt=1, rvalid 1 cycle later), Instr_ready=1 → Imem_addr 0,2,4,6…; first Instr_valid 3 cycles after reset release, with Instr_pc=0x0000, then one per cycle.
- Instr_ready=0 for 10 cycles → exactly 2 fetches (0x0000, 0x0002), Imem_req=0 thereafter. Raise ready → instructions 0x0000, 0x0002, 0x0004 delivered in order, none dropped.
- Redirect to 0x0040 while 2 fetches are in flight → both responses discarded, next Imem_addr=0x0040, first Instr_pc after redirect=0x0040.
- Redirect in the same cycle as gnt and rvalid → granted and returning fetches both dropped; Outstanding=0 and buffer empty after the edge.
- PC at 0xFFFE, fetch granted → next Imem_addr=0x0000, Instr_pc sequence 0xFFFE, 0x0000.
- Halt=1 with 1 outstanding → response delivered, no further Imem_req. Redirect to 0x0100 → RUN, fetch 0x0100. Assert Reset_n=0 mid-run → all outputs 0 asynchronously, and Imem_addr=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU defaults and the fetch-unit state encoding.
//   CPU_ADDR_W   - default instruction-address width
//   CPU_INSTR_W  - default instruction width
//   CPU_RESET_PC - default reset program counter
//   fetch_state_e - IDLE / RUN / HALTED fetch FSM states
package cpu_pkg;
    localparam int CPU_ADDR_W   = 16;
    localparam int CPU_INSTR_W  = 16;
    localparam int CPU_RESET_PC = 0;
    typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous flush.
//   clk, rst_n - clock, asynchronous active-low reset
//   flush      - empty the FIFO at the next edge (wins over push/pop)
//   push, din  - write strobe and data
//   pop        - read strobe; dout always shows the head entry
//   full, empty, count - occupancy status, all derived from registers
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    always_comb begin
        wr_d  = flush ? '0 : wr_q + AW'(push);
        rd_d  = flush ? '0 : rd_q + AW'(pop);
        cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_q] <= din;
    end
    assign dout  = mem_q[rd_q];
    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign count = cnt_q;
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter plus instruction fetch with buffering.
//   clk, rst_n                 - clock, asynchronous active-low reset
//   redirect_valid/redirect_pc - load new PC, flush buffer and in-flight fetches
//   halt                       - level; stops new fetch issue
//   imem_req/addr/gnt          - request side of the instruction-memory port
//   imem_rvalid/rdata          - in-order response side
//   instr_valid/ready/instr/instr_pc - buffered instruction to decode
//   outstanding                - fetches in flight that will be kept
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = CPU_ADDR_W,
    parameter int                INSTR_W   = CPU_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(CPU_RESET_PC),
    parameter int                BUF_DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_pc,
    input  logic                         halt,
    output logic                         imem_req,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic                         imem_gnt,
    input  logic                         imem_rvalid,
    input  logic [INSTR_W-1:0]           imem_rdata,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [INSTR_W-1:0]           instr,
    output logic [ADDR_W-1:0]            instr_pc,
    output logic [$clog2(BUF_DEPTH):0]   outstanding
);
    localparam int STEP = INSTR_W / 8;
    localparam int CW   = $clog2(BUF_DEPTH) + 1;
    localparam int SW   = CW + 2;

    fetch_state_e              state_q, state_d;
    logic [ADDR_W-1:0]         pc_q, pc_d;
    logic [CW-1:0]             outst_q, outst_d, drop_q, drop_d;
    logic [CW-1:0]             occ, tag_cnt;
    logic                      fire, rsp_keep, buf_push, buf_pop;
    logic                      buf_empty, buf_full, tag_full, tag_empty;
    logic [ADDR_W-1:0]         tag;
    logic [INSTR_W+ADDR_W-1:0] buf_dout;

    // Every slot that a kept or dropped response could still claim counts
    // against the buffer, so a granted fetch always has room to land.
    assign imem_req = state_q == RUN && !halt &&
                      (SW'(occ) + SW'(outst_q) + SW'(drop_q) < SW'(BUF_DEPTH));
    assign fire     = imem_req && imem_gnt;
    assign rsp_keep = imem_rvalid && drop_q == '0;
    assign buf_push = rsp_keep && !redirect_valid;
    assign buf_pop  = !buf_empty && instr_ready && !redirect_valid;

    always_comb begin
        state_d = (state_q == IDLE) ? RUN :
                  (state_q == RUN)  ? ((halt && !redirect_valid) ? HALTED : RUN) :
                  (redirect_valid || !halt) ? RUN : HALTED;
        pc_d    = redirect_valid ? (redirect_pc & ~ADDR_W'(STEP - 1)) :
                  fire           ? pc_q + ADDR_W'(STEP) : pc_q;
        outst_d = redirect_valid ? '0 : outst_q + CW'(fire) - CW'(rsp_keep);
        // On redirect everything still in flight becomes a drop; a response
        // arriving now retires one of them whichever counter it belonged to.
        drop_d  = redirect_valid ? drop_q + outst_q + CW'(fire) - CW'(imem_rvalid) :
                                   drop_q - CW'(imem_rvalid && drop_q != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    // Tags are never flushed: dropped responses still pop their own tag.
    sync_fifo #(.W(ADDR_W), .DEPTH(BUF_DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (1'b0),
        .push  (fire),
        .din   (pc_q),
        .pop   (imem_rvalid),
        .dout  (tag),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_cnt)
    );

    sync_fifo #(.W(INSTR_W + ADDR_W), .DEPTH(BUF_DEPTH)) u_instr_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (buf_push),
        .din   ({imem_rdata, tag}),
        .pop   (buf_pop),
        .dout  (buf_dout),
        .full  (buf_full),
        .empty (buf_empty),
        .count (occ)
    );

    assign imem_addr   = pc_q;
    assign instr_valid = !buf_empty;
    assign instr       = instr_valid ? buf_dout[INSTR_W+ADDR_W-1 -: INSTR_W] : '0;
    assign instr_pc    = instr_valid ? buf_dout[ADDR_W-1:0] : '0;
    assign outstanding = outst_q;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(buf_push && buf_full && !buf_pop));
            assert (!(fire && tag_full && !imem_rvalid));
            assert (!(imem_rvalid && tag_empty));
            assert (tag_cnt == outst_q + drop_q);
        end
    end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed self-checking bench for pc_fetch_unit.
module tb_pc_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [1:0]  outstanding;

    int          tests = 0;
    int          fails = 0;
    int          fires = 0;
    logic        auto_rsp;
    logic [15:0] pend [$];

    pc_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .outstanding    (outstanding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: record a grant, then present the oldest pending response
    // in the following cycle (memory data = ~address).
    task automatic tick();
        if (imem_req && imem_gnt) begin
            pend.push_back(imem_addr);
            fires++;
        end
        @(posedge clk);
        #1;
        if (auto_rsp && pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~pend.pop_front();
        end else begin
            imem_rvalid = 1'b0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        imem_rvalid    = 1'b0;
        pend.delete();
        @(posedge clk);
        @(posedge clk);
        #2;
        fires = 0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        instr_ready = 1'b1; auto_rsp = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_outst", outstanding, 0);

        // Streaming with zero-wait memory
        do_reset();
        chk("idle_no_req", imem_req, 0);
        tick();
        chk("s_req0", imem_req, 1);
        chk("s_addr0", imem_addr, 16'h0000);
        tick();
        chk("s_addr2", imem_addr, 16'h0002);
        chk("s_outst1", outstanding, 1);
        chk("s_valid_early", instr_valid, 0);
        tick();
        chk("s_valid", instr_valid, 1);
        chk("s_pc0", instr_pc, 16'h0000);
        chk("s_instr0", instr, 16'hFFFF);
        chk("s_req_cap", imem_req, 0);
        tick();
        chk("s_pc2", instr_pc, 16'h0002);
        chk("s_instr2", instr, 16'hFFFD);
        chk("s_addr4", imem_addr, 16'h0004);
        chk("s_req4", imem_req, 1);

        // Decode stalled
        instr_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        chk("st_fires", fires, 2);
        chk("st_req", imem_req, 0);
        chk("st_addr", imem_addr, 16'h0004);
        chk("st_outst", outstanding, 0);
        chk("st_head", instr_pc, 16'h0000);
        instr_ready = 1'b1;
        tick();
        chk("st_pc2", instr_pc, 16'h0002);
        tick();
        chk("st_gap", instr_valid, 0);
        tick();
        chk("st_pc4", instr_pc, 16'h0004);
        chk("st_instr4", instr, 16'hFFFB);

        // Redirect with two fetches in flight
        auto_rsp = 1'b0;
        do_reset();
        repeat (3) tick();
        chk("r_outst2", outstanding, 2);
        chk("r_req_cap", imem_req, 0);
        auto_rsp = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 16'h0041;
        tick();
        redirect_valid = 1'b0;
        chk("r_outst0", outstanding, 0);
        chk("r_req_drop", imem_req, 0);
        chk("r_addr", imem_addr, 16'h0040);
        chk("r_flushed", instr_valid, 0);
        tick();
        chk("r_req40", imem_req, 1);
        chk("r_addr40", imem_addr, 16'h0040);
        chk("r_drop1", instr_valid, 0);
        tick();
        chk("r_drop2", instr_valid, 0);
        tick();
        chk("r_valid", instr_valid, 1);
        chk("r_pc40", instr_pc, 16'h0040);
        chk("r_instr40", instr, 16'hFFBF);

        // Redirect coinciding with gnt and rvalid
        tick();
        tick();
        chk("g_req", imem_req, 1);
        chk("g_addr46", imem_addr, 16'h0046);
        chk("g_outst1", outstanding, 1);
        redirect_valid = 1'b1; redirect_pc = 16'h0080;
        tick();
        redirect_valid = 1'b0;
        chk("g_outst0", outstanding, 0);
        chk("g_empty", instr_valid, 0);
        chk("g_addr80", imem_addr, 16'h0080);
        chk("g_req80", imem_req, 1);
        tick();
        chk("g_dropped", instr_valid, 0);
        tick();
        chk("g_pc80", instr_pc, 16'h0080);
        chk("g_instr80", instr, 16'hFF7F);

        // PC wrap
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect_valid = 1'b0;
        chk("w_req", imem_req, 1);
        chk("w_addr_fffe", imem_addr, 16'hFFFE);
        tick();
        chk("w_addr_wrap", imem_addr, 16'h0000);
        tick();
        chk("w_pc_fffe", instr_pc, 16'hFFFE);
        chk("w_instr_fffe", instr, 16'h0001);
        tick();
        chk("w_pc_0000", instr_pc, 16'h0000);
        chk("w_addr2", imem_addr, 16'h0002);

        // Halt with one fetch outstanding
        tick();
        halt = 1'b1;
        #1;
        chk("h_req_off", imem_req, 0);
        chk("h_outst1", outstanding, 1);
        tick();
        chk("h_valid", instr_valid, 1);
        chk("h_pc2", instr_pc, 16'h0002);
        chk("h_outst0", outstanding, 0);
        repeat (4) tick();
        chk("h_drained", instr_valid, 0);
        chk("h_fires", fires, 3);
        chk("h_req_still", imem_req, 0);
        halt = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0100;
        tick();
        redirect_valid = 1'b0;
        chk("h_req100", imem_req, 1);
        chk("h_addr100", imem_addr, 16'h0100);
        tick();
        chk("h_addr102", imem_addr, 16'h0102);
        chk("h_outst_run", outstanding, 1);

        // Asynchronous reset mid-run
        #3 rst_n = 1'b0;
        #1;
        chk("ar_req", imem_req, 0);
        chk("ar_addr", imem_addr, 16'h0000);
        chk("ar_valid", instr_valid, 0);
        chk("ar_instr", instr, 0);
        chk("ar_instr_pc", instr_pc, 0);
        chk("ar_outst", outstanding, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
